// File: rtl/ps2_kbscan_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbscan_if
// Description : PS/2 line, keymap load, matrix read and event bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_kbscan_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                   ps2clk;
    logic                   ps2dat;
    logic                   mapwe;
    logic [8:0]             mapaddr;
    logic [7:0]             mapdata;
    logic                   clrall;
    logic [ROWS-1:0]        rowsel;
    logic [COLS-1:0]        kbdata;
    logic [ROWS*COLS-1:0]   kbmat_out;
    logic                   keyev;
    logic [6:0]             keyidx;
    logic                   keyrel;
    logic [7:0]             errcnt;

    modport slave (
        input  ps2clk, ps2dat, mapwe, mapaddr, mapdata, clrall, rowsel,
        output kbdata, kbmat_out, keyev, keyidx, keyrel, errcnt
    );

    modport master (
        output ps2clk, ps2dat, mapwe, mapaddr, mapdata, clrall, rowsel,
        input  kbdata, kbmat_out, keyev, keyidx, keyrel, errcnt
    );
endinterface
`default_nettype wire

// File: rtl/ps2_kbscan.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbscan
// Description : PS/2 keyboard receiver feeding a ROWS x COLS key matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbscan #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 20000
) (
    input  wire logic     clk,
    input  wire logic     reset,
    ps2_kbscan_if.slave   bus
);
    localparam int unsigned        C_NKEYS     = ROWS * COLS;
    localparam int                 C_TOW       = $clog2(TIMEOUT + 1);
    localparam logic [C_TOW-1:0]   C_TO_LAST   = C_TOW'(TIMEOUT - 1);
    localparam logic [3:0]         C_FILT_LAST = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic                 r_filt, r_fall;
    logic [3:0]           r_fcnt;
    logic [C_TOW-1:0]     r_tocnt;
    logic                 w_timeout, w_acc, w_ferr;
    logic [7:0]           r_shift, r_byte;
    logic [2:0]           r_bitcnt, r_skip;
    logic                 r_par, r_byte_vld, r_ext, r_rls;
    logic                 w_rd_en, w_ovr, r_rd_vld, r_rd_rls;
    logic [7:0]           r_map [512];
    logic [7:0]           r_rdata;
    logic [6:0]           w_idx;
    logic                 w_hit;
    logic [C_NKEYS-1:0]   w_keysel, w_kbmat_upd, r_kbmat;
    logic                 r_keyev, r_keyrel;
    logic [6:0]           r_keyidx;
    logic [7:0]           r_errcnt;
    logic [COLS-1:0]      w_kbdata;

    // The filtered clock only flips after FILTER_LEN agreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_fcnt   <= 4'd0;
            r_fall   <= 1'b0;
        end else begin
            r_clk_s1 <= bus.ps2clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2dat;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= 4'd0;
            end else if (r_fcnt == C_FILT_LAST) begin
                r_filt <= r_clk_s2;
                r_fcnt <= 4'd0;
                r_fall <= r_filt;
            end else begin
                r_fcnt <= r_fcnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            r_tocnt <= '0;
        else if (r_fall || r_state == S_IDLE) r_tocnt <= '0;
        else                                  r_tocnt <= r_tocnt + 1'b1;
    end

    assign w_timeout = (r_state != S_IDLE) && !r_fall && (r_tocnt == C_TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc       = 1'b0;
        w_ferr      = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_ferr      = 1'b1;
        end else if (r_fall) begin
            case (r_state)
                S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                default: begin
                    w_state_nxt = S_IDLE;
                    if (r_dat_s2 && (^r_shift ^ r_par)) w_acc  = 1'b1;
                    else                                w_ferr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= 8'd0;
            r_bitcnt   <= 3'd0;
            r_par      <= 1'b0;
            r_byte     <= 8'd0;
            r_byte_vld <= 1'b0;
        end else begin
            r_byte_vld <= w_acc;
            if (w_acc) r_byte <= r_shift;
            if (r_fall) begin
                case (r_state)
                    S_IDLE:   r_bitcnt <= 3'd0;
                    S_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: r_par <= r_dat_s2;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_en = 1'b0;
        w_ovr   = 1'b0;
        if (r_byte_vld && !w_ferr && r_skip == 3'd0) begin
            case (r_byte)
                8'hE1, 8'hE0, 8'hF0: ;
                8'hFF, 8'h00:        w_ovr   = 1'b1;
                default:             w_rd_en = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ext    <= 1'b0;
            r_rls    <= 1'b0;
            r_skip   <= 3'd0;
            r_rd_vld <= 1'b0;
            r_rd_rls <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_rd_en) r_rd_rls <= r_rls;
            if (w_ferr) begin
                r_ext  <= 1'b0;
                r_rls  <= 1'b0;
                r_skip <= 3'd0;
            end else if (r_byte_vld) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 3'd1;
                end else begin
                    case (r_byte)
                        8'hE1:   r_skip <= 3'd7;
                        8'hE0:   r_ext  <= 1'b1;
                        8'hF0:   r_rls  <= 1'b1;
                        default: begin
                            r_ext <= 1'b0;
                            r_rls <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Keymap survives reset; a same-address read returns the pre-write entry.
    always_ff @(posedge clk) begin
        if (bus.mapwe) r_map[bus.mapaddr] <= bus.mapdata;
        if (w_rd_en)   r_rdata <= r_map[{r_ext, r_byte}];
    end

    assign w_idx = r_rdata[6:0];
    assign w_hit = r_rd_vld && r_rdata[7] && (32'(w_idx) < C_NKEYS);

    for (genvar b = 0; b < int'(C_NKEYS); b++) begin : g_key
        assign w_keysel[b] = (32'(w_idx) == b);
    end

    assign w_kbmat_upd = (r_kbmat & ~w_keysel) | (w_keysel & {C_NKEYS{~r_rd_rls}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kbmat  <= '0;
            r_keyev  <= 1'b0;
            r_keyidx <= 7'd0;
            r_keyrel <= 1'b0;
            r_errcnt <= 8'd0;
        end else begin
            r_keyev <= w_hit;
            if (w_hit) begin
                r_kbmat  <= w_kbmat_upd;
                r_keyidx <= w_idx;
                r_keyrel <= r_rd_rls;
            end
            if (w_ovr || bus.clrall) r_kbmat <= '0;
            if (w_ferr && r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'd1;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic w_any;
        always_comb begin
            w_any = 1'b0;
            for (int r = 0; r < ROWS; r++)
                w_any = w_any | (~bus.rowsel[r] & r_kbmat[r*COLS + c]);
        end
        assign w_kbdata[c] = ~w_any;
    end

    assign bus.kbdata    = w_kbdata;
    assign bus.kbmat_out = r_kbmat;
    assign bus.keyev     = r_keyev;
    assign bus.keyidx    = r_keyidx;
    assign bus.keyrel    = r_keyrel;
    assign bus.errcnt    = r_errcnt;
endmodule
`default_nettype wire

// File: tb/tb_ps2_kbscan.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbscan
// Description : Directed vector bench for the PS/2 keyboard matrix receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbscan;
    localparam int C_TO = 2000;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   ev_cnt = 0;

    ps2_kbscan_if #(.ROWS(8), .COLS(8)) bus ();

    ps2_kbscan #(.ROWS(8), .COLS(8), .FILTER_LEN(4), .TIMEOUT(C_TO)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.keyev === 1'b1) ev_cnt <= ev_cnt + 1;

    typedef struct {
        logic [7:0]  code;
        logic        good;
        logic [7:0]  rowsel;
        logic [63:0] mat;
        int          ev;
        logic [6:0]  idx;
        logic        rel;
        logic [7:0]  err;
        logic [7:0]  kbd;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(logic [7:0] code, logic good, logic [7:0] rs,
                                logic [63:0] m, int ev, logic [6:0] idx,
                                logic rel, logic [7:0] err, logic [7:0] kd);
        vec_t v;
        v.code = code; v.good = good; v.rowsel = rs; v.mat = m; v.ev = ev;
        v.idx = idx; v.rel = rel; v.err = err; v.kbd = kd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic map_wr(input logic [8:0] a, input logic [7:0] d);
        bus.mapaddr = a;
        bus.mapdata = d;
        bus.mapwe   = 1'b1;
        @(negedge clk);
        bus.mapwe   = 1'b0;
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2dat = b;
        repeat (5) @(negedge clk);
        bus.ps2clk = 1'b0;
        repeat (10) @(negedge clk);
        bus.ps2clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic good, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (good ? ~(^d) : ^d), d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        bus.ps2dat = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input logic [63:0] m, input int ev,
                             input logic [6:0] idx, input logic rel, input logic [7:0] err);
        chk({tag, " mat"}, bus.kbmat_out, m);
        chk({tag, " evcnt"}, 64'(ev_cnt), 64'(ev));
        chk({tag, " keyidx"}, 64'(bus.keyidx), 64'(idx));
        chk({tag, " keyrel"}, 64'(bus.keyrel), 64'(rel));
        chk({tag, " errcnt"}, 64'(bus.errcnt), 64'(err));
    endtask

    initial begin
        logic [63:0] b43, b14, b1, b2, b3;
        b43 = 64'd1 << 43;
        b14 = 64'd1 << 14;
        b1  = 64'd1 << 1;
        b2  = 64'd1 << 2;
        b3  = 64'd1 << 3;

        vecs[0]  = mk(8'h1C, 1, 8'hDF, b43,       1, 43, 0, 0, 8'hF7);
        vecs[1]  = mk(8'hF0, 1, 8'hFF, b43,       1, 43, 0, 0, 8'hFF);
        vecs[2]  = mk(8'h1C, 1, 8'hDF, 64'd0,     2, 43, 1, 0, 8'hFF);
        vecs[3]  = mk(8'hE0, 1, 8'hFF, 64'd0,     2, 43, 1, 0, 8'hFF);
        vecs[4]  = mk(8'h75, 1, 8'hFD, b14,       3, 14, 0, 0, 8'hBF);
        vecs[5]  = mk(8'h75, 1, 8'hFD, b14,       3, 14, 0, 0, 8'hBF);
        vecs[6]  = mk(8'h22, 1, 8'hFF, b14,       3, 14, 0, 0, 8'hFF);
        vecs[7]  = mk(8'h1C, 1, 8'h00, b14 | b43, 4, 43, 0, 0, 8'hB7);
        vecs[8]  = mk(8'h1C, 0, 8'h00, b14 | b43, 4, 43, 0, 1, 8'hB7);
        vecs[9]  = mk(8'hF0, 1, 8'h00, b14 | b43, 4, 43, 0, 1, 8'hB7);
        vecs[10] = mk(8'h1C, 1, 8'hDF, b14,       5, 43, 1, 1, 8'hFF);
        vecs[11] = mk(8'hF0, 1, 8'hFF, b14,       5, 43, 1, 1, 8'hFF);
        vecs[12] = mk(8'h1C, 0, 8'hFF, b14,       5, 43, 1, 2, 8'hFF);
        vecs[13] = mk(8'h1C, 1, 8'hDF, b14 | b43, 6, 43, 0, 2, 8'hF7);
        vecs[14] = mk(8'hE0, 1, 8'hFF, b14 | b43, 6, 43, 0, 2, 8'hFF);
        vecs[15] = mk(8'h75, 0, 8'hFF, b14 | b43, 6, 43, 0, 3, 8'hFF);
        vecs[16] = mk(8'h75, 1, 8'hFD, b14 | b43, 6, 43, 0, 3, 8'hBF);
        vecs[17] = mk(8'h1C, 1, 8'hDF, b14 | b43, 7, 43, 0, 3, 8'hF7);

        rst = 1'b1;
        bus.ps2clk = 1'b1;  bus.ps2dat = 1'b1;
        bus.mapwe = 1'b0;   bus.mapaddr = 9'd0;  bus.mapdata = 8'd0;
        bus.clrall = 1'b0;  bus.rowsel = 8'hFF;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        bus.rowsel = 8'h00;
        chk_state("reset", 64'd0, 0, 7'd0, 1'b0, 8'd0);
        chk("reset keyev", 64'(bus.keyev), 64'd0);
        chk("reset kbdata", 64'(bus.kbdata), 64'hFF);

        for (int a = 0; a < 512; a++) map_wr(9'(a), 8'h00);
        map_wr({1'b0, 8'h1C}, 8'hAB);
        map_wr({1'b1, 8'h75}, 8'h8E);
        map_wr({1'b0, 8'h75}, 8'h05);
        map_wr({1'b0, 8'h22}, 8'hC8);
        map_wr({1'b0, 8'h14}, 8'h81);
        map_wr({1'b0, 8'h1D}, 8'h82);
        map_wr({1'b0, 8'h1B}, 8'h83);
        map_wr({1'b0, 8'h77}, 8'h84);

        for (int i = 0; i < 18; i++) begin
            bus.rowsel = vecs[i].rowsel;
            send_frame(vecs[i].code, vecs[i].good, 11);
            chk_state($sformatf("vec%0d", i), vecs[i].mat, vecs[i].ev,
                      vecs[i].idx, vecs[i].rel, vecs[i].err);
            chk($sformatf("vec%0d kbdata", i), 64'(bus.kbdata), 64'(vecs[i].kbd));
        end
        bus.rowsel = 8'hFF;

        // Partial frame abandoned, then recovery
        send_frame(8'h1C, 1, 5);
        repeat (C_TO + 10) @(negedge clk);
        chk_state("timeout", b14 | b43, 7, 43, 0, 8'd4);
        send_frame(8'hF0, 1, 11);
        send_frame(8'h1C, 1, 11);
        chk_state("after timeout", b14, 8, 43, 1, 8'd4);

        // Pause sequence must be swallowed whole
        foreach (vecs[i]) ; // no-op to keep loop style uniform
        send_frame(8'hE1, 1, 11); send_frame(8'h14, 1, 11);
        send_frame(8'h77, 1, 11); send_frame(8'hE1, 1, 11);
        send_frame(8'hF0, 1, 11); send_frame(8'h14, 1, 11);
        send_frame(8'hF0, 1, 11); send_frame(8'h77, 1, 11);
        chk_state("pause", b14, 8, 43, 1, 8'd4);

        // Overrun codes
        send_frame(8'h14, 1, 11); send_frame(8'h1D, 1, 11); send_frame(8'h1B, 1, 11);
        chk_state("three keys", b14 | b1 | b2 | b3, 11, 3, 0, 8'd4);
        send_frame(8'hFF, 1, 11);
        chk_state("overrun FF", 64'd0, 11, 3, 0, 8'd4);
        send_frame(8'h1D, 1, 11);
        chk_state("press 1D", b2, 12, 2, 0, 8'd4);
        send_frame(8'h00, 1, 11);
        chk_state("overrun 00", 64'd0, 12, 2, 0, 8'd4);

        // clrall level clear and override of a coincident update
        send_frame(8'h1B, 1, 11);
        bus.clrall = 1'b1;
        repeat (3) @(negedge clk);
        chk("clrall level", bus.kbmat_out, 64'd0);
        send_frame(8'h1C, 1, 11);
        chk_state("clrall update", 64'd0, 14, 43, 0, 8'd4);
        bus.clrall = 1'b0;
        @(negedge clk);

        // Single-clock glitches while data is low must not start a frame
        bus.ps2dat = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 6; g++) begin
            bus.ps2clk = 1'b0;
            @(negedge clk);
            bus.ps2clk = 1'b1;
            repeat (8) @(negedge clk);
        end
        bus.ps2dat = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h1C, 1, 11);
        chk_state("glitch", b43, 15, 43, 0, 8'd4);

        // Reset in the middle of a frame
        send_frame(8'h1D, 1, 6);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_state("midframe reset", 64'd0, 15, 7'd0, 1'b0, 8'd0);
        repeat (C_TO + 10) @(negedge clk);
        chk("post reset errcnt", 64'(bus.errcnt), 64'd0);
        send_frame(8'h1C, 1, 11);
        chk_state("after reset", b43, 16, 43, 0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
